// File: rtl/csa_resolver.sv
// Multi-cycle carry-propagate resolver: turns a carry-save (sum, carry) pair into
// its binary total sum + 2*carry, CHUNK bits per clock, with valid/ready on both sides.
module csa_resolver #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_result
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RESOLVE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             top_reg;
  logic [KW-1:0]    k_reg;
  logic             c_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH+1:0] result_reg;

  logic [CHUNK-1:0] a_chunk [N];
  logic [CHUNK-1:0] b_chunk [N];
  logic [CHUNK-1:0] a_sel;
  logic [CHUNK-1:0] b_sel;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] r_next;
  logic [1:0]       hi_next;

  // Split operands into chunks and splice the freshly resolved chunk into the result.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chunk
      assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
      assign r_next[gi*CHUNK +: CHUNK] = (k_reg == KW'(gi)) ? chunk_sum[CHUNK-1:0]
                                                            : r_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (k_reg == KW'(i)) begin
        a_sel = a_chunk[i];
        b_sel = b_chunk[i];
      end
    end
  end

  assign chunk_sum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, c_reg};
  // The carry-vector MSB was shifted out of B, so it re-enters here at weight 2^WIDTH.
  assign hi_next   = {1'b0, chunk_sum[CHUNK]} + {1'b0, top_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      top_reg    <= 1'b0;
      k_reg      <= '0;
      c_reg      <= 1'b0;
      r_reg      <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_sum;
            b_reg     <= {in_carry[WIDTH-2:0], 1'b0};
            top_reg   <= in_carry[WIDTH-1];
            k_reg     <= '0;
            c_reg     <= 1'b0;
            state_reg <= RESOLVE;
          end
        end
        RESOLVE: begin
          r_reg <= r_next;
          c_reg <= chunk_sum[CHUNK];
          k_reg <= k_reg + KW'(1);
          if (k_reg == K_LAST) begin
            result_reg <= {hi_next, r_next};
            state_reg  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_reg == IDLE) && !rst;
  assign out_valid  = (state_reg == DONE);
  assign out_result = result_reg;

endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: directed corner cases plus a randomized full-adder-row
// stream checked in order against plain integer addition.
module tb_csa_resolver;

  localparam int WIDTH = 8;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum = '0;
  logic [WIDTH-1:0] in_carry = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH+1:0] out_result;

  int total = 0;
  int bad   = 0;

  csa_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    int v;
    v = int'(s) + 2 * int'(c);
    return v[WIDTH+1:0];
  endfunction

  // Drive one pair for exactly one clock edge; returns at the negedge after that edge.
  task automatic start_op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    @(negedge clk);
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sum   = $urandom;
    in_carry = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat <= 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL reset_out_result got=%h want=000", out_result); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    $display("reset: in_ready=%b out_valid=%b out_result=%h", in_ready, out_valid, out_result);
  endtask

  task automatic test_directed(input string name, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                               input logic [WIDTH+1:0] want);
    int lat;
    start_op(s, c);
    wait_valid(lat);
    total++; if (lat != N) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, N); end
    total++; if (out_result !== want) begin bad++; $display("FAIL %s_result got=%h want=%h", name, out_result, want); end
    total++; if (out_result !== model(s, c)) begin bad++; $display("FAIL %s_model got=%h want=%h", name, out_result, model(s, c)); end
    $display("%s: sum=%h carry=%h result=%h latency=%0d", name, s, c, out_result, lat);
    finish_op();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_handoff got valid=%b ready=%b want valid=0 ready=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    start_op(8'h35, 8'h12);
    wait_valid(lat);
    total++; if (lat != N) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, N); end
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 10'h059) begin
        bad++; $display("FAIL bp_stall%0d got valid=%b ready=%b result=%h want 1 0 059", i, out_valid, in_ready, out_result);
      end
      in_valid = (i == 2);
      in_sum   = 8'hAA;
      in_carry = 8'h55;
      @(negedge clk);
    end
    in_valid = 1'b0;
    finish_op();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 10'h059) begin
      bad++; $display("FAIL bp_release got valid=%b ready=%b result=%h want 0 1 059", out_valid, in_ready, out_result);
    end
    repeat (4) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_ignored_input got valid=%b want=0", out_valid); end
    $display("back_pressure: result=059 held 5 cycles, stray input ignored");
  endtask

  task automatic test_reset_mid_resolve();
    int lat;
    start_op(8'hFF, 8'hFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0 || out_result !== '0) begin
      bad++; $display("FAIL midrst_cleared got valid=%b result=%h want 0 000", out_valid, out_result);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_emit%0d got=%b want=0", i, out_valid); end
    end
    start_op(8'h80, 8'h80);
    wait_valid(lat);
    total++; if (lat != N || out_result !== 10'h180) begin
      bad++; $display("FAIL midrst_next got result=%h lat=%0d want 180 lat=%0d", out_result, lat, N);
    end
    $display("reset_mid_resolve: next result=%h", out_result);
    finish_op();
  endtask

  task automatic test_random();
    logic [WIDTH+1:0] exp_q[$];
    int sent = 0;
    int got  = 0;
    int drv_cycles = 0;
    int mon_cycles = 0;
    fork
      begin : driver
        for (int n = 0; n < 1000; n++) begin
          logic [WIDTH-1:0] a, b, c;
          int gap;
          a = $urandom; b = $urandom; c = $urandom;
          gap = $urandom_range(0, 3);
          repeat (gap) @(negedge clk);
          in_sum   = a ^ b ^ c;
          in_carry = (a & b) | (a & c) | (b & c);
          in_valid = 1'b1;
          while (!in_ready && drv_cycles < 60000) begin @(negedge clk); drv_cycles++; end
          exp_q.push_back(10'(int'(a) + int'(b) + int'(c)));
          sent++;
          @(negedge clk);
          in_valid = 1'b0;
          in_sum   = $urandom;
          in_carry = $urandom;
        end
      end
      begin : monitor
        while (got < 1000 && mon_cycles < 80000) begin
          logic r;
          @(negedge clk);
          mon_cycles++;
          r = ($urandom_range(0, 1) == 1);
          if (out_valid && r) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++; $display("FAIL rand_extra got result=%h want no output", out_result);
            end else if (out_result !== exp_q[0]) begin
              bad++; $display("FAIL rand_%0d got=%h want=%h", got, out_result, exp_q[0]);
              void'(exp_q.pop_front());
            end else begin
              void'(exp_q.pop_front());
            end
            got++;
          end
          out_ready = r;
        end
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    total++; if (got != 1000 || sent != 1000 || exp_q.size() != 0) begin
      bad++; $display("FAIL rand_count got sent=%0d recv=%0d pending=%0d want 1000 1000 0", sent, got, exp_q.size());
    end
    $display("random: sent=%0d received=%0d", sent, got);
  endtask

  initial begin
    test_reset();
    test_directed("zeros", 8'h00, 8'h00, 10'h000);
    test_directed("saturated", 8'hFF, 8'hFF, 10'h2FD);
    test_directed("chunk_carry", 8'h0F, 8'h01, 10'h011);
    test_back_pressure();
    test_reset_mid_resolve();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
